// File: rtl/vc_input_buffer.sv
// vc_input_buffer: one flit FIFO per VC for a router input port, presents head of vc_sel, returns credits upstream.
// Latency: a pushed flit is visible from the next cycle (no bypass); a credit pulses the cycle after each accepted pop.
// Backpressure: credit-based, no ready; pushes to a full VC are dropped, flagged sticky when VC_BUF_OVF_CHECK_EN is defined.
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif

module vc_input_buffer #(
  parameter int VC_NUM = 4,
  parameter int VC_W   = 2,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_valid_in,
  input  logic [VC_W-1:0]       flit_vc_in,
  input  logic [1:`FLIT_SIZE]   flit_in,
  input  logic [VC_W-1:0]       vc_sel,
  input  logic                  pop,
  output logic [1:`FLIT_SIZE]   flit_out,
  output logic [0:VC_NUM-1]     is_new_flit,
  output logic                  credit_out,
  output logic [VC_W-1:0]       credit_vc_out,
  output logic                  overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [1:`FLIT_SIZE] mem    [VC_NUM][DEPTH];
  logic [PW-1:0]       wr_ptr [VC_NUM];
  logic [PW-1:0]       rd_ptr [VC_NUM];
  logic [PW:0]         cnt    [VC_NUM];

  logic                push_ok;
  logic                pop_ok;
  logic [VC_NUM-1:0]   push_v;
  logic [VC_NUM-1:0]   pop_v;

  // Accept decisions; a full VC still takes a flit when the same VC is popped this cycle.
  always_comb begin
    push_v  = '0;
    pop_v   = '0;
    pop_ok  = pop && (cnt[vc_sel] != '0);
    push_ok = flit_valid_in &&
              ((cnt[flit_vc_in] != FULL) || (pop_ok && (vc_sel == flit_vc_in)));
    for (int v = 0; v < VC_NUM; v++) begin
      push_v[v] = push_ok && (flit_vc_in == VC_W'(v));
      pop_v[v]  = pop_ok  && (vc_sel == VC_W'(v));
    end
  end

  // Flit storage is deliberately not reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[flit_vc_in][wr_ptr[flit_vc_in]] <= flit_in;
  end

  // Per-VC pointers and occupancy; push and pop on the same VC leave cnt unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push_v[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (pop_v[v])  rd_ptr[v] <= rd_ptr[v] + PW'(1);
        if (push_v[v] && !pop_v[v])      cnt[v] <= cnt[v] + (PW+1)'(1);
        else if (!push_v[v] && pop_v[v]) cnt[v] <= cnt[v] - (PW+1)'(1);
      end
    end
  end

  // Non-empty flags feed the VC/input arbitration chain.
  always_comb begin
    is_new_flit = '0;
    for (int v = 0; v < VC_NUM; v++) is_new_flit[v] = (cnt[v] != '0);
  end

  assign flit_out = (cnt[vc_sel] != '0) ? mem[vc_sel][rd_ptr[vc_sel]] : '0;

  // One credit per accepted pop; the VC tag holds when idle, reset kills any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_out    <= 1'b0;
      credit_vc_out <= '0;
    end else if (pop_ok) begin
      credit_out    <= 1'b1;
      credit_vc_out <= vc_sel;
    end else begin
      credit_out    <= 1'b0;
    end
  end

`ifdef VC_BUF_OVF_CHECK_EN
  // Sticky flag: any flit arriving at a full VC without a same-VC pop is lost.
  always_ff @(posedge clk) begin
    if (reset)                           overflow_err <= 1'b0;
    else if (flit_valid_in && !push_ok)  overflow_err <= 1'b1;
  end
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif

module tb_vc_input_buffer;

  localparam int VC_NUM = 4;
  localparam int VC_W   = 2;
  localparam int DEPTH  = 4;
`ifdef VC_BUF_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                flit_valid_in;
  logic [VC_W-1:0]     flit_vc_in;
  logic [1:`FLIT_SIZE] flit_in;
  logic [VC_W-1:0]     vc_sel;
  logic                pop;
  logic [1:`FLIT_SIZE] flit_out;
  logic [0:VC_NUM-1]   is_new_flit;
  logic                credit_out;
  logic [VC_W-1:0]     credit_vc_out;
  logic                overflow_err;

  int vectors = 0;
  int errors  = 0;

  // Reference model: one queue per VC plus registered credit/overflow state.
  logic [1:`FLIT_SIZE] m_q [VC_NUM][$];
  bit                  m_cr;
  logic [VC_W-1:0]     m_cvc;
  bit                  m_ovf;

  vc_input_buffer #(.VC_NUM(VC_NUM), .VC_W(VC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in),
    .flit_in(flit_in), .vc_sel(vc_sel), .pop(pop), .flit_out(flit_out),
    .is_new_flit(is_new_flit), .credit_out(credit_out), .credit_vc_out(credit_vc_out),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs currently driven, then clock the DUT and settle.
  task automatic tick();
    bit pop_ok, push_ok;
    int pv, iv;
    pv = int'(vc_sel);
    iv = int'(flit_vc_in);
    pop_ok  = pop && (m_q[pv].size() > 0);
    push_ok = flit_valid_in && ((m_q[iv].size() < DEPTH) || (pop_ok && pv == iv));
    if (reset) begin
      for (int v = 0; v < VC_NUM; v++) m_q[v].delete();
      m_cr = 0; m_cvc = '0; m_ovf = 0;
    end else begin
      if (pop_ok) begin
        void'(m_q[pv].pop_front());
        m_cr = 1; m_cvc = vc_sel;
      end else m_cr = 0;
      if (push_ok) m_q[iv].push_back(flit_in);
      if (flit_valid_in && !push_ok && OVF_EN) m_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [0:VC_NUM-1]   e_nf;
    logic [1:`FLIT_SIZE] e_head;
    int sv;
    sv = int'(vc_sel);
    for (int v = 0; v < VC_NUM; v++) e_nf[v] = (m_q[v].size() > 0);
    e_head = (m_q[sv].size() > 0) ? m_q[sv][0] : '0;
    chk({tag, ".is_new_flit"}, 32'(is_new_flit), 32'(e_nf));
    chk({tag, ".flit_out"}, 32'(flit_out), 32'(e_head));
    chk({tag, ".credit_out"}, 32'(credit_out), 32'(m_cr));
    if (m_cr) chk({tag, ".credit_vc"}, 32'(credit_vc_out), 32'(m_cvc));
    chk({tag, ".overflow"}, 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic drive(input bit v, input int vc, input int f, input bit p, input int sel);
    flit_valid_in = v;
    flit_vc_in    = VC_W'(vc);
    flit_in       = `FLIT_SIZE'(f);
    pop           = p;
    vc_sel        = VC_W'(sel);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    chk("rst.is_new_flit", 32'(is_new_flit), 32'h0);
    chk("rst.flit_out", 32'(flit_out), 32'h0);
    chk("rst.credit_out", 32'(credit_out), 32'h0);
    chk("rst.credit_vc", 32'(credit_vc_out), 32'h0);
    chk("rst.overflow", 32'(overflow_err), 32'h0);

    // Three flits into VC2, then drain with credits.
    drive(1, 2, 8'h11, 0, 2); tick(); check_all("vc2.push0");
    chk("vc2.nf_first", 32'(is_new_flit), 32'b0010);
    chk("vc2.head_first", 32'(flit_out), 32'h11);
    drive(1, 2, 8'h22, 0, 2); tick(); check_all("vc2.push1");
    drive(1, 2, 8'h33, 0, 2); tick(); check_all("vc2.push2");
    chk("vc2.head_still", 32'(flit_out), 32'h11);
    drive(0, 0, 0, 1, 2); tick(); check_all("vc2.pop0");
    chk("vc2.pop0_head", 32'(flit_out), 32'h22);
    chk("vc2.pop0_cr", 32'({credit_out, credit_vc_out}), 32'b110);
    tick(); check_all("vc2.pop1");
    chk("vc2.pop1_head", 32'(flit_out), 32'h33);
    tick(); check_all("vc2.pop2");
    chk("vc2.pop2_head", 32'(flit_out), 32'h0);
    chk("vc2.pop2_cr", 32'({credit_out, credit_vc_out}), 32'b110);
    chk("vc2.empty", 32'(is_new_flit), 32'b0000);
    drive(0, 0, 0, 0, 2); tick(); check_all("vc2.idle");
    chk("vc2.idle_cr", 32'({credit_out, credit_vc_out}), 32'b010);

    // Overfill VC0: fifth flit dropped.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 8'hA0 + i, 0, 0); tick(); check_all("vc0.fill");
    end
    drive(1, 0, 8'hA4, 0, 0); tick(); check_all("vc0.ovf");
    chk("vc0.ovf_flag", 32'(overflow_err), 32'(OVF_EN));
    drive(0, 0, 0, 0, 0); tick(); check_all("vc0.ovf_hold");
    chk("vc0.ovf_sticky", 32'(overflow_err), 32'(OVF_EN));
    for (int i = 0; i < DEPTH; i++) begin
      chk("vc0.drain_head", 32'(flit_out), 32'h0A0 + 32'(i));
      drive(0, 0, 0, 1, 0); tick(); check_all("vc0.drain");
    end
    chk("vc0.no_fifth", 32'(flit_out), 32'h0);
    chk("vc0.ovf_after", 32'(overflow_err), 32'(OVF_EN));
    reset = 1'b1; drive(0, 0, 0, 0, 0); tick(); reset = 1'b0;
    chk("rst2.overflow", 32'(overflow_err), 32'h0);

    // VC1 full: simultaneous push and pop, new flit lands after wrap.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 8'hB0 + i, 0, 1); tick(); check_all("vc1.fill");
    end
    drive(1, 1, 8'hB4, 1, 1); tick(); check_all("vc1.pushpop");
    chk("vc1.pp_ovf", 32'(overflow_err), 32'h0);
    chk("vc1.pp_nf", 32'(is_new_flit[1]), 32'h1);
    chk("vc1.pp_head", 32'(flit_out), 32'hB1);
    for (int i = 2; i <= DEPTH; i++) begin
      drive(0, 0, 0, 1, 1); tick(); check_all("vc1.drain");
      chk("vc1.drain_head", 32'(flit_out), (i == DEPTH) ? 32'hB4 : 32'h0B0 + 32'(i));
    end
    drive(0, 0, 0, 1, 1); tick(); check_all("vc1.last");
    chk("vc1.empty", 32'(flit_out), 32'h0);

    // Push VC3 while popping VC0.
    drive(1, 0, 8'hC0, 0, 0); tick();
    drive(1, 0, 8'hC1, 0, 0); tick(); check_all("x.pre");
    drive(1, 3, 8'hD0, 1, 0); tick(); check_all("x.both");
    chk("x.nf", 32'(is_new_flit), 32'b1001);
    chk("x.cr", 32'({credit_out, credit_vc_out}), 32'b100);
    chk("x.head", 32'(flit_out), 32'hC1);
    drive(0, 0, 0, 0, 0); tick(); check_all("x.single");
    chk("x.single_cr", 32'(credit_out), 32'h0);

    // Pop on empty VC1 is ignored.
    drive(0, 0, 0, 1, 1); tick(); check_all("e.pop");
    chk("e.cr", 32'({credit_out, credit_vc_out}), 32'b000);
    chk("e.nf", 32'(is_new_flit), 32'b1001);
    drive(0, 0, 0, 0, 0); tick();

    // Reset right after a pop: pending credit suppressed.
    drive(1, 2, 8'hE0, 0, 2); tick();
    drive(1, 2, 8'hE1, 0, 2); tick();
    drive(0, 0, 0, 1, 2); tick(); check_all("r.pop");
    chk("r.pop_cr", 32'(credit_out), 32'h1);
    reset = 1'b1; tick(); check_all("r.rst");
    chk("r.cr", 32'(credit_out), 32'h0);
    chk("r.cvc", 32'(credit_vc_out), 32'h0);
    chk("r.nf", 32'(is_new_flit), 32'h0);
    chk("r.head", 32'(flit_out), 32'h0);
    reset = 1'b0; drive(0, 0, 0, 0, 2); tick(); check_all("r.after");
    chk("r.after_nf", 32'(is_new_flit), 32'h0);

    // Random mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), $urandom_range(0, VC_NUM-1), $urandom_range(0, 255),
            bit'($urandom_range(0, 2) == 0), $urandom_range(0, VC_NUM-1));
      tick(); check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
